// File: rtl/uart_loader.sv
// Packet loader behind uart_rx: parses sync/CMD/ADDR/LEN/DATA frames, writes words to program memory, gates CPU reset.
// Define UART_LOADER_CSUM_EN to expect and verify a trailing XOR checksum byte.
module uart_loader #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic              busy
);
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [7:0]       CMD_WRITE = 8'h01;
    localparam logic [7:0]       CMD_RUN   = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR_L = 3'd2,
        S_ADDR_H = 3'd3,
        S_LEN    = 3'd4,
        S_DATA   = 3'd5
`ifdef UART_LOADER_CSUM_EN
        ,S_CSUM  = 3'd6
`endif
    } state_t;

    // Where a packet goes once its payload is complete.
`ifdef UART_LOADER_CSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_IDLE;
`endif

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic               cmd_run_r;
    logic [7:0]         addr_lo_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [8:0]         word_cnt_r;
    logic [1:0]         byte_cnt_r;
    logic [23:0]        shift_r;
    logic [CNT_W-1:0]   idle_cnt_r;
`ifdef UART_LOADER_CSUM_EN
    logic [7:0]         csum_r;
`endif

    logic               timeout_s;
    logic               cmd_ok_s;
    logic               word_last_s;
    logic               pkt_last_s;
    logic               mem_we_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [31:0]        mem_wdata_s;
    logic               cpu_hold_s;
    logic               done_s;
    logic               error_s;
    logic               busy_s;

    // A timeout can only fire on a cycle without a byte, so a late byte always wins.
    assign timeout_s   = (state_r != S_IDLE) && !rx_ready && (idle_cnt_r == CNT_LAST);
    assign cmd_ok_s    = (rx_data == CMD_WRITE) || (rx_data == CMD_RUN);
    assign word_last_s = (byte_cnt_r == 2'd3);
    assign pkt_last_s  = word_last_s && (word_cnt_r == 9'd1);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state selection; every transition is gated by a received byte except the timeout.
    always_comb begin
        state_nx_s = state_r;
        if (timeout_s) begin
            state_nx_s = S_IDLE;
        end else if (rx_ready) begin
            case (state_r)
                S_IDLE:   state_nx_s = (rx_data == SYNC_BYTE) ? S_CMD : S_IDLE;
                S_CMD:    state_nx_s = cmd_ok_s ? S_ADDR_L : S_IDLE;
                S_ADDR_L: state_nx_s = S_ADDR_H;
                S_ADDR_H: state_nx_s = S_LEN;
                S_LEN:    state_nx_s = cmd_run_r ? S_TAIL : S_DATA;
                S_DATA:   state_nx_s = pkt_last_s ? S_TAIL : S_DATA;
`ifdef UART_LOADER_CSUM_EN
                S_CSUM:   state_nx_s = S_IDLE;
`endif
                default:  state_nx_s = S_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr;
        mem_wdata_s = mem_wdata;
        cpu_hold_s  = cpu_hold;
        done_s      = 1'b0;
        error_s     = error;
        busy_s      = (state_nx_s != S_IDLE);
        if (timeout_s) begin
            error_s = 1'b1;
        end else if (rx_ready) begin
            case (state_r)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) error_s = 1'b0;
                    else                      error_s = error;
                end
                S_CMD: begin
                    if (!cmd_ok_s) error_s = 1'b1;
                    else           error_s = error;
                end
                S_LEN: begin
                    if (!cmd_run_r) begin
                        cpu_hold_s = 1'b1;
                    end else begin
`ifdef UART_LOADER_CSUM_EN
                        cpu_hold_s = cpu_hold;
`else
                        cpu_hold_s = 1'b0;
                        done_s     = 1'b1;
`endif
                    end
                end
                S_DATA: begin
                    if (word_last_s) begin
                        mem_we_s    = 1'b1;
                        mem_addr_s  = addr_r;
                        mem_wdata_s = {rx_data, shift_r};
`ifndef UART_LOADER_CSUM_EN
                        done_s      = pkt_last_s;
`endif
                    end else begin
                        mem_we_s    = 1'b0;
                    end
                end
`ifdef UART_LOADER_CSUM_EN
                S_CSUM: begin
                    if (rx_data == csum_r) begin
                        done_s = 1'b1;
                        if (cmd_run_r) cpu_hold_s = 1'b0;
                        else           cpu_hold_s = cpu_hold;
                    end else begin
                        error_s = 1'b1;
                    end
                end
`endif
                default: done_s = 1'b0;
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    // Packet datapath: command, address, word/byte counters, word assembly and idle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_run_r  <= 1'b0;
            addr_lo_r  <= 8'h00;
            addr_r     <= {ADDR_W{1'b0}};
            word_cnt_r <= 9'd0;
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'h000000;
            idle_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((state_r == S_IDLE) || rx_ready || timeout_s) begin
                idle_cnt_r <= {CNT_W{1'b0}};
            end else begin
                idle_cnt_r <= idle_cnt_r + CNT_W'(1);
            end
            if (rx_ready) begin
                case (state_r)
                    S_CMD:    cmd_run_r <= (rx_data == CMD_RUN);
                    S_ADDR_L: addr_lo_r <= rx_data;
                    S_ADDR_H: addr_r    <= ADDR_W'({rx_data, addr_lo_r});
                    S_LEN: begin
                        word_cnt_r <= {(rx_data == 8'h00), rx_data};
                        byte_cnt_r <= 2'd0;
                    end
                    S_DATA: begin
                        shift_r    <= {rx_data, shift_r[23:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (word_last_s) begin
                            word_cnt_r <= word_cnt_r - 9'd1;
                            addr_r     <= addr_r + ADDR_W'(1);
                        end
                    end
                    default: cmd_run_r <= cmd_run_r;
                endcase
            end
        end
    end

`ifdef UART_LOADER_CSUM_EN
    // Running XOR of every byte after sync; the CMD byte restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_r <= 8'h00;
        end else if (rx_ready) begin
            if (state_r == S_CMD) csum_r <= rx_data;
            else                  csum_r <= csum_step(csum_r, rx_data);
        end
    end
`endif

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= 32'h0000_0000;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_we    <= mem_we_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
            cpu_hold  <= cpu_hold_s;
            done      <= done_s;
            error     <= error_s;
            busy      <= busy_s;
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: two instances (12-bit and 4-bit address) share one byte stream and are
// checked against a packet-level model of expected writes, done pulses, cpu_hold and error.
module tb_uart_loader;
    localparam int TIMEOUT = 100;
`ifdef UART_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we_a, hold_a, done_a, error_a, busy_a;
    logic [11:0] addr_a;
    logic [31:0] wdata_a;
    logic        we_b, hold_b, done_b, error_b, busy_b;
    logic [3:0]  addr_b;
    logic [31:0] wdata_b;

    logic [31:0] cyc = 32'd0;
    wr_t         wr_a[$];
    wr_t         wr_b[$];
    logic [31:0] dn_a[$];
    logic [31:0] dn_b[$];
    logic [31:0] pkt_words[$];
    logic        exp_hold;
    logic        exp_err;
    int          errors = 0;
    int          checks = 0;

    uart_loader #(.ADDR_W(12), .TIMEOUT(TIMEOUT)) dut_a (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .cpu_hold(hold_a),
        .done(done_a), .error(error_a), .busy(busy_a)
    );

    uart_loader #(.ADDR_W(4), .TIMEOUT(TIMEOUT)) dut_b (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .cpu_hold(hold_b),
        .done(done_b), .error(error_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Write and done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t w;
        if (we_a === 1'b1) begin
            w.addr = 16'(addr_a); w.data = wdata_a; w.cyc = cyc;
            wr_a.push_back(w);
        end
        if (we_b === 1'b1) begin
            w.addr = 16'(addr_b); w.data = wdata_b; w.cyc = cyc;
            wr_b.push_back(w);
        end
        if (done_a === 1'b1) dn_a.push_back(cyc);
        if (done_b === 1'b1) dn_b.push_back(cyc);
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        wr_a.delete(); wr_b.delete(); dn_a.delete(); dn_b.delete();
    endtask

    // Drives one byte starting at a falling edge; t is the cycle number before the sampling edge.
    task automatic send_byte(input logic [7:0] b, output logic [31:0] t);
        rx_data  = b;
        rx_ready = 1'b1;
        t        = cyc;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_noise(input int n);
        logic [7:0]  b;
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, t);
        end
    endtask

    task automatic check_status(input string tag, input logic hold, input logic err, input logic bsy);
        check_value({tag, "_hold_a"}, hold_a, hold);
        check_value({tag, "_hold_b"}, hold_b, hold);
        check_value({tag, "_err_a"}, error_a, err);
        check_value({tag, "_err_b"}, error_b, err);
        check_value({tag, "_busy_a"}, busy_a, bsy);
        check_value({tag, "_busy_b"}, busy_b, bsy);
    endtask

    // Sends one framed packet built from pkt_words and compares everything the model predicts.
    task automatic run_packet(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] len,
                              input bit bad_csum, input int max_gap, input int slow_idx, input int slow_gap);
        logic [7:0]  bytes[$];
        logic [31:0] tc[$];
        logic [31:0] t;
        logic [31:0] ecyc;
        logic [15:0] ea;
        logic [7:0]  cs;
        int          nw;
        bit          ok;
        nw = (cmd == CMD_WRITE) ? ((len == 8'd0) ? 256 : int'(len)) : 0;
        bytes.push_back(8'hA5);
        bytes.push_back(cmd);
        bytes.push_back(addr[7:0]);
        bytes.push_back(addr[15:8]);
        bytes.push_back(len);
        for (int i = 0; i < nw; i++)
            for (int k = 0; k < 4; k++) bytes.push_back(pkt_words[i][8*k +: 8]);
        cs = 8'h00;
        for (int i = 1; i < bytes.size(); i++) cs = cs ^ bytes[i];
        if (CSUM_EN) bytes.push_back(bad_csum ? cs + 8'd1 : cs);
        ok = !(CSUM_EN && bad_csum);
        clear_obs();
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], t);
            tc.push_back(t);
            if (i == 0) begin
                check_value("sync_err_clear_a", error_a, 1'b0);
                check_value("sync_err_clear_b", error_b, 1'b0);
                check_value("sync_busy_a", busy_a, 1'b1);
            end
            if (i == bytes.size() - 1) begin
                if (cmd == CMD_WRITE) exp_hold = 1'b1;
                else if (ok)          exp_hold = 1'b0;
                exp_err = !ok;
                check_value("end_done_a", done_a, ok);
                check_value("end_done_b", done_b, ok);
                check_status("end", exp_hold, exp_err, 1'b0);
            end
            if (i == slow_idx) repeat (slow_gap) @(negedge clk);
            else               repeat ($urandom_range(max_gap)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check_value("wr_count_a", wr_a.size(), nw);
        check_value("wr_count_b", wr_b.size(), nw);
        for (int i = 0; i < nw; i++) begin
            ea   = addr + 16'(i);
            ecyc = tc[8 + 4*i] + 32'd1;
            if (i < wr_a.size()) begin
                check_value($sformatf("wr_addr_a[%0d]", i), wr_a[i].addr, ea & 16'h0FFF);
                check_value($sformatf("wr_data_a[%0d]", i), wr_a[i].data, pkt_words[i]);
                check_value($sformatf("wr_cyc_a[%0d]", i), wr_a[i].cyc, ecyc);
            end
            if (i < wr_b.size()) begin
                check_value($sformatf("wr_addr_b[%0d]", i), wr_b[i].addr, ea & 16'h000F);
                check_value($sformatf("wr_data_b[%0d]", i), wr_b[i].data, pkt_words[i]);
                check_value($sformatf("wr_cyc_b[%0d]", i), wr_b[i].cyc, ecyc);
            end
        end
        check_value("done_count_a", dn_a.size(), ok ? 1 : 0);
        check_value("done_count_b", dn_b.size(), ok ? 1 : 0);
        if (ok && dn_a.size() > 0) check_value("done_cyc_a", dn_a[0], tc[tc.size() - 1] + 32'd1);
    endtask

    initial begin
        logic [31:0] t;
        logic [31:0] t_last;
        logic [31:0] t_err;
        bit          found;
        logic [7:0]  cmd;
        logic [7:0]  len;

        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        exp_hold = 1'b1;
        exp_err  = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_we_a", we_a, 1'b0);
        check_value("rst_addr_a", addr_a, 12'h000);
        check_value("rst_wdata_a", wdata_a, 32'h0);
        check_value("rst_done_a", done_a, 1'b0);
        check_value("rst_addr_b", addr_b, 4'h0);
        check_status("rst", 1'b1, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Idle noise followed by the reference WRITE at 0x010.
        send_noise(5);
        check_value("noise_busy_a", busy_a, 1'b0);
        pkt_words = '{32'h44332211, 32'h88776655};
        run_packet(CMD_WRITE, 16'h0010, 8'd2, 1'b0, 2, -1, 0);

        // RUN with zero address/length.
        run_packet(CMD_RUN, 16'h0000, 8'h00, 1'b0, 0, -1, 0);

        // WRITE with a corrupted checksum, then a good RUN.
        pkt_words = '{32'hDEADBEEF};
        run_packet(CMD_WRITE, 16'h0123, 8'd1, 1'b1, 1, -1, 0);
        run_packet(CMD_RUN, 16'h5555, 8'h03, 1'b0, 1, -1, 0);

        // Bad command.
        clear_obs();
        send_byte(8'hA5, t);
        send_byte(8'h7F, t);
        exp_err = 1'b1;
        check_status("badcmd", exp_hold, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_value("badcmd_no_we", wr_a.size(), 0);

        // Silence after ADDR_H.
        clear_obs();
        send_byte(8'hA5, t);
        send_byte(CMD_WRITE, t);
        send_byte(8'h40, t);
        send_byte(8'h00, t);
        t_last = t;
        found  = 1'b0;
        t_err  = 32'd0;
        for (int k = 0; k < 3 * TIMEOUT && !found; k++) begin
            if (error_a === 1'b1) begin
                found = 1'b1;
                t_err = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check_value("timeout_latency", t_err, t_last + 32'd1 + 32'(TIMEOUT));
        exp_err = 1'b1;
        check_status("timeout", exp_hold, 1'b1, 1'b0);
        check_value("timeout_no_we", wr_a.size(), 0);

        // A byte landing on the would-be timeout cycle is still accepted.
        run_packet(CMD_RUN, 16'h1234, 8'h07, 1'b0, 1, 3, TIMEOUT - 1);

        // Address wrap, with sync bytes appearing as data.
        pkt_words = '{32'hA5A5A5A5, 32'h0102A503};
        run_packet(CMD_WRITE, 16'h000F, 8'd2, 1'b0, 0, -1, 0);

        // Randomized packets.
        for (int p = 0; p < 12; p++) begin
            send_noise($urandom_range(2));
            cmd = ($urandom_range(9) < 7) ? CMD_WRITE : CMD_RUN;
            len = 8'($urandom_range(6, 1));
            pkt_words.delete();
            for (int i = 0; i < 6; i++) pkt_words.push_back($urandom);
            run_packet(cmd, 16'($urandom), len, ($urandom_range(3) == 0), 3, -1, 0);
        end

        // LEN=0 means 256 words, back to back.
        pkt_words.delete();
        for (int i = 0; i < 256; i++) pkt_words.push_back($urandom);
        run_packet(CMD_WRITE, 16'h0FF0, 8'h00, 1'b0, 0, -1, 0);

        // Reset in the middle of a data word.
        run_packet(CMD_RUN, 16'h0000, 8'h00, 1'b0, 0, -1, 0);
        clear_obs();
        send_byte(8'hA5, t);
        send_byte(CMD_WRITE, t);
        send_byte(8'h20, t);
        send_byte(8'h00, t);
        send_byte(8'h01, t);
        send_byte(8'h11, t);
        @(negedge clk);
        send_byte(8'h22, t);
        reset_n = 1'b0;
        #1;
        check_value("midrst_we_a", we_a, 1'b0);
        check_value("midrst_addr_a", addr_a, 12'h000);
        check_value("midrst_wdata_a", wdata_a, 32'h0);
        check_value("midrst_done_a", done_a, 1'b0);
        check_status("midrst", 1'b1, 1'b0, 1'b0);
        exp_hold = 1'b1;
        exp_err  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_byte(8'h33, t);
        send_byte(8'h44, t);
        send_byte(8'h67, t);
        repeat (3) @(negedge clk);
        check_value("resume_no_we_a", wr_a.size(), 0);
        check_value("resume_no_we_b", wr_b.size(), 0);
        check_value("resume_no_done", dn_a.size(), 0);
        check_status("resume", 1'b1, 1'b0, 1'b0);

        // Normal operation after the reset.
        pkt_words = '{32'hCAFEF00D};
        run_packet(CMD_WRITE, 16'h0ABC, 8'd1, 1'b0, 2, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
# uart_loader

Packet-level controller sitting behind `uart_rx`. It consumes the received byte stream (`rx_data`/`rx_ready`) and parses framed loader packets. It sequences word writes into instruction/data memory and holds the CPU in reset until a valid RUN packet arrives. It is the host-side boot path of the CPU and the only writer of program memory during load.

## Interface
- `ADDR_W`, 12: word-address width of `mem_addr`.
- `TIMEOUT`, 1000000: max idle clk cycles between bytes inside a packet.
- `clk` in 1: system clock (same clock as `uart_rx`).
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from `uart_rx`, valid while `rx_ready`=1.
- `rx_ready` in 1: single-cycle byte strobe from `uart_rx`.
- `mem_we` out 1: one-cycle memory write strobe.
- `mem_addr` out ADDR_W: word address of the current write.
- `mem_wdata` out 32: word to write.
- `cpu_hold` out 1: 1 = CPU held in reset.
- `done` out 1: one-cycle pulse on successful packet completion.
- `error` out 1: sticky error flag.
- `busy` out 1: 1 while FSM is not in IDLE.

## Operation
- Packet: `0xA5` sync, CMD, ADDR_L, ADDR_H, LEN, then for WRITE 4×N data bytes (little-endian words), then CSUM. N = LEN, LEN=0 means 256.
- CMD 0x01 = WRITE. CMD 0x02 = RUN. A RUN packet still carries ADDR/LEN bytes, and they are ignored.
- CSUM = XOR of every byte after sync, up to the last data byte.
- FSM states: IDLE, CMD, ADDR_L, ADDR_H, LEN, DATA, CSUM. Each advances only on a cycle with `rx_ready`=1.
- IDLE: any byte ≠ 0xA5 is discarded. A 0xA5 byte moves to CMD and clears `error`.
- CMD: 0x01/0x02 move to ADDR_L. Any other value sets `error` and returns to IDLE.
- ADDR_L/ADDR_H: load the address register. Bits above ADDR_W are dropped.
- LEN: WRITE goes to DATA, loads the word counter, and asserts `cpu_hold`=1. RUN goes to CSUM.
- DATA: shifts each byte into a 32-bit assembly register, low byte first. After each 4th byte:
  - `mem_we` pulses.
  - The address increments afterwards and wraps modulo 2^ADDR_W.
  - The word counter decrements. Moves to CSUM after word N.
- CSUM, on match: `done` pulses. For RUN, `cpu_hold` drops to 0.
- CSUM, on mismatch: `error` is set, `cpu_hold` is unchanged, and words already written stay written.
- From CSUM, the FSM always returns to IDLE.
- Timeout: the idle counter resets on every `rx_ready` and counts only outside IDLE. Reaching TIMEOUT sets `error` and forces IDLE.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `busy`=0. State is IDLE and all counters are 0.
- `mem_we` is registered: high the cycle after the `rx_ready` of the 4th byte of a word. `mem_addr`/`mem_wdata` are stable in that cycle.
- `done`, `error` and the `cpu_hold` release are registered and appear the cycle after the CSUM `rx_ready`.
- A new byte may arrive the cycle right after `mem_we`. There is no back-pressure, and the memory must accept a write every cycle.
- Timeout and `rx_ready` in the same cycle: the byte is processed and the counter clears. No timeout.
- A 0xA5 byte outside IDLE is ordinary data, with no resync.
- Asserting `reset_n` mid-packet aborts immediately. `cpu_hold` returns to 1 and no partial `mem_we` is issued.

## Configuration
- `UART_LOADER_CSUM_EN` defined:
  - CSUM byte expected and checked as above.
- `UART_LOADER_CSUM_EN` undefined:
  - No CSUM state. The packet ends after the last data word (WRITE) or after LEN (RUN).
  - `done` pulses, and for RUN `cpu_hold` drops, the cycle after that final `rx_ready`.
  - Checksum `error` is never raised. Timeout and bad-CMD errors remain.

## Test plan
- WRITE, addr 0x010, LEN 2, data 11 22 33 44 / 55 66 77 88, correct CSUM. Required:
  - `mem_we` at 0x010 = 0x44332211, then at 0x011 = 0x88776655.
  - `done` pulses once, `cpu_hold` stays 1.
- RUN packet A5 02 00 00 00 02 (CSUM 0x02) → `cpu_hold` falls 1 cycle after the last byte, `done`=1 for one cycle, `error`=0.
- WRITE LEN 1 with CSUM off by one → one `mem_we`, then `error`=1, no `done`. A following valid RUN clears `error` at sync and releases `cpu_hold`.
- Bad CMD 0x7F after sync → `error`=1, `busy`=0 the next cycle, no `mem_we`.
- Stop sending bytes after ADDR_H (with TIMEOUT=100 in the bench) → `error`=1 exactly 100 cycles after the last `rx_ready`, FSM in IDLE.
- Address wrap: ADDR_W=4, WRITE addr 0xF, LEN 2 → writes at 0xF then 0x0.
- Reset mid-DATA after 2 bytes → all outputs at reset values, and no `mem_we` on resume.
